kv_arbiter: RTL

- Round-robin arbiter sharing one keyvalue store (8-bit key/value, Wishbone-like STB/WE/ACK handshake) among N_REQ requesters.
- Captures the winning request, issues it to the store, waits for ACK, and returns read data plus a one-cycle ACK to the winner.
- A store read-miss never ACKs, so the arbiter bounds each transaction with a watchdog. On expiry it returns ERR and pulses the store's active-high reset to recover it.
- Sits between bus masters and the store instance.

---
 rtl/kv_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/kv_arbiter.sv
// Round-robin arbiter that shares one key/value store among N_REQ bus masters,
// with a per-transaction watchdog that aborts and resets the store on a read miss.
module kv_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [N_REQ-1:0]   req_stb_i,
    input  logic [N_REQ-1:0]   req_we_i,
    input  logic [N_REQ-1:0]   req_adr_is_key_i,
    input  logic [N_REQ-1:0]   req_dat_is_key_i,
    input  logic [8*N_REQ-1:0] req_adr_i,
    input  logic [8*N_REQ-1:0] req_dat_i,
    output logic [N_REQ-1:0]   req_ack_o,
    output logic [N_REQ-1:0]   req_err_o,
    output logic [7:0]         req_dat_o,
    output logic               kv_stb_o,
    output logic               kv_cyc_o,
    output logic               kv_we_o,
    output logic               kv_adr_is_key_o,
    output logic               kv_dat_is_key_o,
    output logic [7:0]         kv_adr_o,
    output logic [7:0]         kv_dat_o,
    input  logic               kv_ack_i,
    input  logic [7:0]         kv_dat_i,
    output logic               kv_abort_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP,
        S_ABORT,
        S_RECOVER
    } state_t;

    // Handshake: a requester raises req_stb_i and holds it until its own
    // one-cycle req_ack_o/req_err_o; the store side sees kv_stb_o held high
    // until kv_ack_i or the watchdog, with kv_* frozen for that whole window.
    state_t             state_q;
    logic [PW-1:0]      ptr_q;
    logic [CW-1:0]      cnt_q;
    logic [N_REQ-1:0]   grant_q;
    logic [N_REQ-1:0]   ack_q;
    logic [N_REQ-1:0]   err_q;
    logic [7:0]         rdat_q;
    logic               stb_q;
    logic               we_q;
    logic               adr_is_key_q;
    logic               dat_is_key_q;
    logic [7:0]         adr_q;
    logic [7:0]         dat_q;
    logic               abort_q;
    logic               busy_q;

    logic               win_vld_d;
    logic [PW-1:0]      win_idx_d;
    logic [N_REQ-1:0]   win_oh_d;
    logic               sel_we_d;
    logic               sel_adr_is_key_d;
    logic               sel_dat_is_key_d;
    logic [7:0]         sel_adr_d;
    logic [7:0]         sel_dat_d;

    // Scan starts one past the last winner so nobody wins twice while others wait.
    always_comb begin
        int            idx;
        logic [PW-1:0] idx_w;
        idx              = 0;
        idx_w            = '0;
        win_vld_d        = 1'b0;
        win_idx_d        = '0;
        win_oh_d         = '0;
        sel_we_d         = 1'b0;
        sel_adr_is_key_d = 1'b0;
        sel_dat_is_key_d = 1'b0;
        sel_adr_d        = '0;
        sel_dat_d        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx   = (int'(ptr_q) + k) % N_REQ;
            idx_w = PW'(idx);
            if (!win_vld_d && req_stb_i[idx_w]) begin
                win_vld_d = 1'b1;
                win_idx_d = idx_w;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (win_idx_d == PW'(i)) begin
                win_oh_d[i]      = win_vld_d;
                sel_we_d         = req_we_i[i];
                sel_adr_is_key_d = req_adr_is_key_i[i];
                sel_dat_is_key_d = req_dat_is_key_i[i];
                sel_adr_d        = req_adr_i[8*i +: 8];
                sel_dat_d        = req_dat_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= PW'(N_REQ - 1);
            cnt_q        <= '0;
            grant_q      <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            rdat_q       <= '0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_is_key_q <= 1'b0;
            dat_is_key_q <= 1'b0;
            adr_q        <= '0;
            dat_q        <= '0;
            abort_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            ack_q   <= '0;
            err_q   <= '0;
            abort_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // The store drops strobes while its ACK is still high.
                    if (!kv_ack_i && win_vld_d) begin
                        state_q      <= S_ISSUE;
                        busy_q       <= 1'b1;
                        stb_q        <= 1'b1;
                        ptr_q        <= win_idx_d;
                        cnt_q        <= '0;
                        grant_q      <= win_oh_d;
                        we_q         <= sel_we_d;
                        adr_is_key_q <= sel_adr_is_key_d;
                        dat_is_key_q <= sel_dat_is_key_d;
                        adr_q        <= sel_adr_d;
                        dat_q        <= sel_dat_d;
                    end
                end
                S_ISSUE: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (kv_ack_i) begin
                        rdat_q  <= kv_dat_i;
                        stb_q   <= 1'b0;
                        ack_q   <= grant_q;
                        state_q <= S_RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rdat_q  <= '0;
                        stb_q   <= 1'b0;
                        err_q   <= grant_q;
                        abort_q <= 1'b1;
                        state_q <= S_ABORT;
                    end
                end
                S_RESP: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                S_ABORT: begin
                    grant_q <= '0;
                    cnt_q   <= '0;
                    state_q <= S_RECOVER;
                end
                S_RECOVER: begin
                    // Two quiet cycles let the store walk out of its own reset.
                    if (cnt_q == CW'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ack_o       = ack_q;
    assign req_err_o       = err_q;
    assign req_dat_o       = rdat_q;
    assign kv_stb_o        = stb_q;
    assign kv_cyc_o        = stb_q;
    assign kv_we_o         = we_q;
    assign kv_adr_is_key_o = adr_is_key_q;
    assign kv_dat_is_key_o = dat_is_key_q;
    assign kv_adr_o        = adr_q;
    assign kv_dat_o        = dat_q;
    assign kv_abort_o      = abort_q;
    assign grant_o         = grant_q;
    assign busy_o          = busy_q;

    a_grant_onehot0 : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        $onehot0(grant_q));
    a_stb_owned : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
        stb_q |-> (busy_q && grant_q != '0));

endmodule
